instr_prefetch_queue: RTL and testbench
=======================================

# instr_prefetch_queue

Instruction prefetch queue between `program_memory` and the decode stage (`Dependency_Check_Block`, `Jump_Control_Block` opcode path, `Stall_Control_Block`). It buffers fetched 32-bit instruction words with their 16-bit fetch addresses. It keeps fetching while decode is stalled and discards all buffered words in one cycle when a jump or interrupt redirects the PC. Decode always sees a NOP (`32'h0000_0000`) when the queue has nothing valid.

## Interface

Parameters:
- `DEPTH`, 4: number of entries; power of two, minimum 2.
- `PTR_W`, `$clog2(DEPTH)`: read/write pointer width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `pm_ins`, input, 32: instruction word from program memory.
- `pm_addr`, input, 16: fetch address of `pm_ins`.
- `pm_valid`, input, 1: `pm_ins`/`pm_addr` valid this cycle.
- `pm_ready`, output, 1: queue accepts a word this cycle.
- `stall`, input, 1: decode cannot consume; head is held.
- `flush`, input, 1: PC redirect (`pc_mux_sel`); discard all contents.
- `ins`, output, 32: head instruction to decode; NOP when `ins_valid`=0.
- `ins_addr`, output, 16: fetch address of head; `16'h0000` when `ins_valid`=0.
- `ins_valid`, output, 1: head holds a real instruction.
- `count`, output, `PTR_W+1`: current occupancy, 0..DEPTH.

## Operation

- **Storage:** circular buffer with `wr_ptr` and `rd_ptr` (`PTR_W` bits, wrap modulo DEPTH) and a `count` register.
- **push:** `pm_valid && pm_ready && !flush`. Writes `{pm_addr, pm_ins}` at `wr_ptr`, then `wr_ptr`+1.
- **pop:** `ins_valid && !stall && !flush`. Then `rd_ptr`+1.
- **`count` update:**
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- **`pm_ready`:** `count != DEPTH`, combinational from registered state only. No dependence on `stall`, so there is no combinational loop.
- **Full:** `pm_ready`=0. A pop in the same cycle does not re-open the slot until the next cycle.
- **Empty:** `ins_valid`=0, `ins`=NOP, `ins_addr`=0. `stall` has no effect.
- **flush:** `wr_ptr`, `rd_ptr` and `count` go to 0 at the next edge. Any push or pop in the same cycle is discarded. Flush has priority over push, pop and stall.
- **reset:** same effect as flush, and also has priority over flush.
- **Head outputs:** `ins`, `ins_addr` and `ins_valid` are driven combinationally from the entry at `rd_ptr` and `count != 0`.

## Timing

- **Reset values** at the edge after `reset`=1:
  - `count`=0, `ins_valid`=0, `ins`=32'h0, `ins_addr`=16'h0, `pm_ready`=1.
  - Pointers are 0.
  - Storage contents are don't-care and never observable.
- **Latency:** a word pushed at edge N is visible at the head from edge N (the same clock edge that writes it). It is consumed no earlier than edge N+1.
- **Throughput:** one push and one pop per cycle, sustained at any occupancy below DEPTH.
- **Stall:** while `stall`=1, `ins`, `ins_addr` and `ins_valid` hold stable. Pushes continue until full.
- **Flush mid-stall:** the queue is empty after the edge. `ins_valid`=0 the following cycle, even if `stall` is still high.
- **Reset mid-operation:** all in-flight words are lost. No partial pointer update occurs.

## Configuration

- **`PREFETCH_BYPASS_EN`:**
  - **Defined:** when `count`=0, `pm_valid`=1, `stall`=0 and `flush`=0, the word goes straight to `ins`/`ins_addr` with `ins_valid`=1 in the same cycle. It is not written to storage and `count` stays 0. This gives zero-cycle latency on an empty queue.
  - **Undefined:** no bypass, and every word passes through storage. An empty queue adds one cycle of latency.
  - **Both modes:** `pm_ready` behaviour is identical.

## Structure

- **Package `mips_pkg`:**
  - `INS_W`=32 and `ADDR_W`=16.
  - `NOP_INS`=32'h0000_0000.
  - Typedef `pq_entry_t` = `{logic [ADDR_W-1:0] addr; logic [INS_W-1:0] ins;}`.
- **Sub-module `pq_storage`:** DEPTH×48-bit register array with one write port and one asynchronous read port. It has no reset, and there is one instance.
- **Top level:** pointer/count control, flush/reset priority and bypass mux stay in `instr_prefetch_queue`.

## Test plan

- **Reset then fill:** reset, then push addresses 0x0000..0x0003 with `stall`=1.
  - Expect `count`=4 and `pm_ready`=0.
  - Expect `ins_addr`=0x0000 held and `ins_valid`=1.
- **Drain in order:** from full, drop `stall` with no pushes.
  - Expect `ins_addr` to sequence 0x0000, 0x0001, 0x0002, 0x0003 on successive cycles.
  - Then expect `ins_valid`=0, `ins`=0 and `count`=0.
- **Wrap-around:** push and pop simultaneously for 10 cycles with `count`=2.
  - Expect `count` constant at 2.
  - Expect output addresses to lag inputs by exactly 2 entries across the pointer wrap.
- **Flush priority:** `count`=3 with `stall`=1; assert `flush` together with `pm_valid` (addr 0x0040).
  - Expect `count`=0 and `ins_valid`=0 next cycle.
  - Expect 0x0040 not stored.
- **Full boundary:** with `count`=4, assert pop and `pm_valid` (addr 0x0050) together.
  - Expect the push refused (`pm_ready`=0) and `count`=3.
  - Next cycle expect `pm_ready`=1 and 0x0050 accepted.
- **Bypass (`PREFETCH_BYPASS_EN` defined):** with the queue empty, present addr 0x0100 with `stall`=0.
  - Expect `ins_addr`=0x0100 and `ins_valid`=1 in the same cycle, with `count`=0.
  - Without the macro, expect `ins_valid`=1 only after the edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch/decode path.
package mips_pkg;

   localparam int INS_W  = 32;
   localparam int ADDR_W = 16;

   // Decode treats an all-zero word as a no-operation.
   localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;

   // One buffered fetch: address in the upper bits, instruction word below.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [INS_W-1:0]  ins;
   } pq_entry_t;

endpackage

// File: rtl/pq_storage.sv
// Entry array for the prefetch queue: one synchronous write port,
// one asynchronous read port, no reset (contents are only ever read
// through an occupied slot).
module pq_storage
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [PTR_W-1:0]          waddr,
   input  logic [ADDR_W+INS_W-1:0]   wdata,
   input  logic [PTR_W-1:0]          raddr,
   output logic [ADDR_W+INS_W-1:0]   rdata
);

   pq_entry_t mem [DEPTH];

   // Write the incoming fetch into its slot.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= pq_entry_t'(wdata);
      end
   end

   // Head slot is visible without a clock edge.
   always_comb begin
      rdata = mem[raddr];
   end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between program memory and decode.
// Circular buffer with read/write pointers and an occupancy counter;
// flush discards everything in one cycle, reset outranks flush.
// Optional feature: define PREFETCH_BYPASS_EN to forward a fetch
// straight to decode when the queue is empty and decode can take it.
module instr_prefetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pm_ins,
   input  logic [15:0]       pm_addr,
   input  logic              pm_valid,
   output logic              pm_ready,
   input  logic              stall,
   input  logic              flush,
   output logic [31:0]       ins,
   output logic [15:0]       ins_addr,
   output logic              ins_valid,
   output logic [PTR_W:0]    count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   cnt;
   logic             head_valid;
   logic             push;
   logic             pop;
   pq_entry_t        wr_entry;
   pq_entry_t        rd_entry;

   assign head_valid = (cnt != '0);
   assign wr_entry   = '{addr: pm_addr, ins: pm_ins};

   // Ready depends only on registered occupancy, never on stall.
   assign pm_ready = (cnt != FULL_CNT);

`ifdef PREFETCH_BYPASS_EN
   logic bypass_take;

   // Empty queue with a fetch decode can consume: hand it over directly.
   assign bypass_take = !head_valid && pm_valid && !stall && !flush;
   assign push        = pm_valid && pm_ready && !flush && !bypass_take;
`else
   assign push        = pm_valid && pm_ready && !flush;
`endif

   // Pop only from a real stored entry; a bypassed word never occupies a slot.
   assign pop = head_valid && !stall && !flush;

   pq_storage #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_storage (
      .clk   (clk),
      .we    (push && !reset),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // Pointer and occupancy update; reset, then flush, then push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Head presented to decode; NOP and zero address whenever nothing is valid.
   always_comb begin
      ins       = NOP_INS;
      ins_addr  = '0;
      ins_valid = 1'b0;
      if (head_valid) begin
         ins       = rd_entry.ins;
         ins_addr  = rd_entry.addr;
         ins_valid = 1'b1;
      end
`ifdef PREFETCH_BYPASS_EN
      else if (bypass_take) begin
         ins       = pm_ins;
         ins_addr  = pm_addr;
         ins_valid = 1'b1;
      end
`endif
   end

   assign count = cnt;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue (DEPTH=4).
module tb_instr_prefetch_queue;

   logic        clk;
   logic        reset;
   logic [31:0] pm_ins;
   logic [15:0] pm_addr;
   logic        pm_valid;
   logic        pm_ready;
   logic        stall;
   logic        flush;
   logic [31:0] ins;
   logic [15:0] ins_addr;
   logic        ins_valid;
   logic [2:0]  count;

   int compared   = 0;
   int mismatched = 0;

   instr_prefetch_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .pm_ins    (pm_ins),
      .pm_addr   (pm_addr),
      .pm_valid  (pm_valid),
      .pm_ready  (pm_ready),
      .stall     (stall),
      .flush     (flush),
      .ins       (ins),
      .ins_addr  (ins_addr),
      .ins_valid (ins_valid),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one fetch; instruction word tagged from the address.
   task automatic drive(input logic v, input logic [15:0] a);
      pm_valid = v;
      pm_addr  = a;
      pm_ins   = 32'hC0DE_0000 | {16'h0, a};
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; stall = 1'b0;
      drive(1'b0, 16'h0);
      #1;
      tick();
      reset = 1'b0;
      #1;
      check("rst_count",    48'(count),     48'd0);
      check("rst_valid",    48'(ins_valid), 48'd0);
      check("rst_ins",      48'(ins),       48'd0);
      check("rst_addr",     48'(ins_addr),  48'd0);
      check("rst_ready",    48'(pm_ready),  48'd1);

      // Fill while decode is stalled.
      stall = 1'b1;
      for (int a = 0; a < 4; a++) begin
         drive(1'b1, 16'(a));
         tick();
         check("fill_head", 48'(ins_addr), 48'h0000);
         check("fill_cnt",  48'(count),    48'(a + 1));
      end
      drive(1'b0, 16'h0);
      #1;
      check("full_ready", 48'(pm_ready),  48'd0);
      check("full_valid", 48'(ins_valid), 48'd1);
      check("full_ins",   48'(ins),       48'hC0DE_0000);

      // Drain in order.
      stall = 1'b0;
      for (int a = 0; a < 4; a++) begin
         #1;
         check("drain_addr", 48'(ins_addr), 48'(a));
         check("drain_ins",  48'(ins),      48'(32'hC0DE_0000 | a));
         tick();
      end
      check("empty_valid", 48'(ins_valid), 48'd0);
      check("empty_ins",   48'(ins),       48'd0);
      check("empty_addr",  48'(ins_addr),  48'd0);
      check("empty_count", 48'(count),     48'd0);

      // Preload two, then push+pop together across pointer wrap.
      stall = 1'b1;
      drive(1'b1, 16'h0010); tick();
      drive(1'b1, 16'h0011); tick();
      check("wrap_pre", 48'(count), 48'd2);
      stall = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 16'(16'h0012 + i));
         #1;
         check("wrap_head", 48'(ins_addr), 48'(16'h0010 + i));
         tick();
         check("wrap_cnt", 48'(count), 48'd2);
      end

      // Flush priority: count 3, stalled, flush with a fetch present.
      stall = 1'b1;
      drive(1'b1, 16'h0030); tick();
      check("pre_flush_cnt", 48'(count), 48'd3);
      flush = 1'b1;
      drive(1'b1, 16'h0040); tick();
      flush = 1'b0;
      drive(1'b0, 16'h0);
      #1;
      check("flush_cnt",   48'(count),     48'd0);
      check("flush_valid", 48'(ins_valid), 48'd0);
      tick();
      check("flush_cnt2",  48'(count),     48'd0);
      drive(1'b1, 16'h0041); tick();
      check("after_flush_head", 48'(ins_addr), 48'h0041);
      check("after_flush_cnt",  48'(count),    48'd1);

      // Full boundary: pop and fetch together while full.
      drive(1'b1, 16'h0042); tick();
      drive(1'b1, 16'h0043); tick();
      drive(1'b1, 16'h0044); tick();
      check("bnd_full", 48'(count), 48'd4);
      stall = 1'b0;
      drive(1'b1, 16'h0050);
      #1;
      check("bnd_ready0", 48'(pm_ready), 48'd0);
      check("bnd_head",   48'(ins_addr), 48'h0041);
      tick();
      check("bnd_cnt3",   48'(count),    48'd3);
      check("bnd_ready1", 48'(pm_ready), 48'd1);
      stall = 1'b1;
      tick();
      check("bnd_cnt4",   48'(count),    48'd4);
      drive(1'b0, 16'h0);
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bnd_drain", 48'(ins_addr), (i == 3) ? 48'h0050 : 48'(16'h0042 + i));
         tick();
      end
      check("bnd_empty", 48'(count), 48'd0);

      // Empty queue with a fetch and no stall.
      drive(1'b1, 16'h0100);
      #1;
`ifdef PREFETCH_BYPASS_EN
      check("byp_valid", 48'(ins_valid), 48'd1);
      check("byp_addr",  48'(ins_addr),  48'h0100);
      check("byp_cnt",   48'(count),     48'd0);
      tick();
      drive(1'b0, 16'h0);
      #1;
      check("byp_after_cnt",   48'(count),     48'd0);
      check("byp_after_valid", 48'(ins_valid), 48'd0);
`else
      check("nobyp_valid", 48'(ins_valid), 48'd0);
      check("nobyp_cnt",   48'(count),     48'd0);
      tick();
      drive(1'b0, 16'h0);
      #1;
      check("nobyp_valid2", 48'(ins_valid), 48'd1);
      check("nobyp_addr2",  48'(ins_addr),  48'h0100);
      check("nobyp_cnt2",   48'(count),     48'd1);
      tick();
      check("nobyp_drained", 48'(ins_valid), 48'd0);
`endif

      // Reset mid-operation overrides a concurrent fetch and flush.
      stall = 1'b1;
      drive(1'b1, 16'h0200); tick();
      drive(1'b1, 16'h0201); tick();
      check("pre_rst_cnt", 48'(count), 48'd2);
      reset = 1'b1;
      flush = 1'b1;
      drive(1'b1, 16'h0202); tick();
      reset = 1'b0;
      flush = 1'b0;
      drive(1'b0, 16'h0);
      #1;
      check("mid_rst_cnt",   48'(count),     48'd0);
      check("mid_rst_valid", 48'(ins_valid), 48'd0);
      check("mid_rst_ready", 48'(pm_ready),  48'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
